// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : Memory-access pipeline stage. Holds one instruction from the
//             execute stage, captures the synchronous data-SRAM read data in
//             the load's first cycle so a stall cannot corrupt it, performs
//             byte/halfword load extraction and presents the writeback value
//             (also used by decode for forwarding).
//  Ports    :
//    clk              in   system clock, rising edge
//    resetn           in   synchronous active-low reset
//    ws_allowin       in   writeback stage can accept this cycle
//    ms_allowin       out  this stage can accept from execute
//    es_to_ms_valid   in   execute presents a valid instruction
//    es_pc            in   [31:0] PC of incoming instruction
//    es_rf_we         in   incoming instruction writes the register file
//    es_rf_waddr      in   [4:0] destination register
//    es_alu_result    in   [31:0] ALU result / load address
//    es_res_from_mem  in   incoming instruction is a load
//    es_ld_op         in   [2:0] load type (W/B/BU/H/HU)
//    data_sram_rdata  in   [31:0] SRAM read data for the load just accepted
//    ms_to_ws_valid   out  valid instruction to writeback
//    ms_pc            out  [31:0] PC of held instruction
//    ms_rf_we         out  register write enable (gated by valid)
//    ms_rf_waddr      out  [4:0] destination register
//    ms_rf_wdata      out  [31:0] final writeback value
//    ms_res_from_mem  out  held instruction is a load (gated by valid)
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ws_allowin,
    output logic        ms_allowin,
    input  logic        es_to_ms_valid,
    input  logic [31:0] es_pc,
    input  logic        es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic [31:0] es_alu_result,
    input  logic        es_res_from_mem,
    input  logic [2:0]  es_ld_op,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic        ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [31:0] ms_rf_wdata,
    output logic        ms_res_from_mem
);

    localparam logic [2:0] C_LD_W  = 3'b000;
    localparam logic [2:0] C_LD_B  = 3'b001;
    localparam logic [2:0] C_LD_BU = 3'b010;
    localparam logic [2:0] C_LD_H  = 3'b011;
    localparam logic [2:0] C_LD_HU = 3'b100;

    logic        valid_q,        valid_d;
    logic [31:0] pc_q,           pc_d;
    logic        rf_we_q,        rf_we_d;
    logic [4:0]  rf_waddr_q,     rf_waddr_d;
    logic [31:0] alu_result_q,   alu_result_d;
    logic        res_from_mem_q, res_from_mem_d;
    logic [2:0]  ld_op_q,        ld_op_d;
    logic [31:0] rdata_buf_q,    rdata_buf_d;
    logic        first_q,        first_d;

    logic        w_accept;
    logic [31:0] w_rdata_sel;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    // ------------------------------------------------------------------
    // Handshake and next-state
    // ------------------------------------------------------------------
    always_comb begin
        ms_allowin = !valid_q || ws_allowin;
        w_accept   = es_to_ms_valid && ms_allowin;

        valid_d        = ms_allowin ? es_to_ms_valid : valid_q;
        pc_d           = w_accept ? es_pc           : pc_q;
        rf_we_d        = w_accept ? es_rf_we        : rf_we_q;
        rf_waddr_d     = w_accept ? es_rf_waddr     : rf_waddr_q;
        alu_result_d   = w_accept ? es_alu_result   : alu_result_q;
        res_from_mem_d = w_accept ? es_res_from_mem : res_from_mem_q;
        ld_op_d        = w_accept ? es_ld_op        : ld_op_q;

        // The SRAM output is only trustworthy in the load's first cycle;
        // execute may re-issue requests while we stall, so snapshot it.
        first_d     = w_accept && es_res_from_mem;
        rdata_buf_d = (first_q && !ws_allowin) ? data_sram_rdata : rdata_buf_q;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q        <= 1'b0;
            pc_q           <= 32'h0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= 5'h0;
            alu_result_q   <= 32'h0;
            res_from_mem_q <= 1'b0;
            ld_op_q        <= 3'b000;
            rdata_buf_q    <= 32'h0;
            first_q        <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            pc_q           <= pc_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            alu_result_q   <= alu_result_d;
            res_from_mem_q <= res_from_mem_d;
            ld_op_q        <= ld_op_d;
            rdata_buf_q    <= rdata_buf_d;
            first_q        <= first_d;
        end
    end

    // ------------------------------------------------------------------
    // Load extraction
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata_sel = first_q ? data_sram_rdata : rdata_buf_q;

        case (alu_result_q[1:0])
            2'd0:    w_byte = w_rdata_sel[7:0];
            2'd1:    w_byte = w_rdata_sel[15:8];
            2'd2:    w_byte = w_rdata_sel[23:16];
            default: w_byte = w_rdata_sel[31:24];
        endcase

        // Halfword select ignores addr[0].
        w_half = alu_result_q[1] ? w_rdata_sel[31:16] : w_rdata_sel[15:0];

        case (ld_op_q)
            C_LD_B:  w_load = {{24{w_byte[7]}}, w_byte};
            C_LD_BU: w_load = {24'h0, w_byte};
            C_LD_H:  w_load = {{16{w_half[15]}}, w_half};
            C_LD_HU: w_load = {16'h0, w_half};
            C_LD_W:  w_load = w_rdata_sel;
            default: w_load = w_rdata_sel;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        ms_to_ws_valid  = valid_q;
        ms_pc           = pc_q;
        ms_rf_we        = valid_q && rf_we_q;
        ms_rf_waddr     = rf_waddr_q;
        ms_res_from_mem = valid_q && res_from_mem_q;
        ms_rf_wdata     = ms_res_from_mem ? w_load : alu_result_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Self-checking bench for mem_stage: table of single-instruction
//             vectors plus hand-written multi-cycle sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic        es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_alu_result;
    logic        es_res_from_mem;
    logic [2:0]  es_ld_op;
    logic [31:0] data_sram_rdata;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic        ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_res_from_mem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_pc           (es_pc),
        .es_rf_we        (es_rf_we),
        .es_rf_waddr     (es_rf_waddr),
        .es_alu_result   (es_alu_result),
        .es_res_from_mem (es_res_from_mem),
        .es_ld_op        (es_ld_op),
        .data_sram_rdata (data_sram_rdata),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_pc           (ms_pc),
        .ms_rf_we        (ms_rf_we),
        .ms_rf_waddr     (ms_rf_waddr),
        .ms_rf_wdata     (ms_rf_wdata),
        .ms_res_from_mem (ms_res_from_mem)
    );

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] alu;
        logic        rfm;
        logic [2:0]  ldop;
        logic [31:0] rdata;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                           input logic [31:0] alu, input logic rfm, input logic [2:0] ldop);
        es_to_ms_valid  = 1'b1;
        es_pc           = pc;
        es_rf_we        = we;
        es_rf_waddr     = waddr;
        es_alu_result   = alu;
        es_res_from_mem = rfm;
        es_ld_op        = ldop;
    endtask

    initial begin
        // pc, we, waddr, alu, rfm, ldop, rdata, expected wdata
        vecs[0]  = '{32'h1C000010, 1'b1, 5'd5,  32'h12345678, 1'b0, 3'd0, 32'hDEAD0000, 32'h12345678};
        vecs[1]  = '{32'h1C000014, 1'b1, 5'd6,  32'h00001001, 1'b1, 3'd1, 32'h80FF7F01, 32'h0000007F};
        vecs[2]  = '{32'h1C000018, 1'b1, 5'd7,  32'h00001001, 1'b1, 3'd2, 32'h80FF7F01, 32'h0000007F};
        vecs[3]  = '{32'h1C00001C, 1'b1, 5'd8,  32'h00001002, 1'b1, 3'd3, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[4]  = '{32'h1C000020, 1'b1, 5'd9,  32'h00001002, 1'b1, 3'd4, 32'h80FF7F01, 32'h000080FF};
        vecs[5]  = '{32'h1C000024, 1'b1, 5'd10, 32'h00001003, 1'b1, 3'd1, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[6]  = '{32'h1C000028, 1'b1, 5'd11, 32'h00001000, 1'b1, 3'd0, 32'h80FF7F01, 32'h80FF7F01};
        vecs[7]  = '{32'h1C00002C, 1'b1, 5'd12, 32'h00001000, 1'b1, 3'd3, 32'h80FF7F01, 32'h00007F01};
        vecs[8]  = '{32'h1C000030, 1'b1, 5'd13, 32'h00001000, 1'b1, 3'd2, 32'h80FF7F01, 32'h00000001};
        vecs[9]  = '{32'h1C000034, 1'b1, 5'd14, 32'h00001002, 1'b1, 3'd1, 32'h80FF7F01, 32'hFFFFFFFF};
        vecs[10] = '{32'h1C000038, 1'b1, 5'd15, 32'h00001003, 1'b1, 3'd4, 32'h80FF7F01, 32'h000080FF};
        vecs[11] = '{32'h1C00003C, 1'b1, 5'd16, 32'h00001001, 1'b1, 3'd5, 32'h80FF7F01, 32'h80FF7F01};
        vecs[12] = '{32'h1C000040, 1'b1, 5'd17, 32'h00001002, 1'b1, 3'd2, 32'h80FF7F01, 32'h000000FF};
        vecs[13] = '{32'h1C000044, 1'b1, 5'd0,  32'hCAFEF00D, 1'b0, 3'd0, 32'h0BADF00D, 32'hCAFEF00D};
        vecs[14] = '{32'h1C000048, 1'b0, 5'd3,  32'h00000042, 1'b0, 3'd0, 32'h0BADF00D, 32'h00000042};

        // ---------------- reset, with execute offering an instruction ----
        resetn          = 1'b0;
        ws_allowin      = 1'b1;
        data_sram_rdata = 32'h0;
        present(32'h1C000000, 1'b1, 5'd1, 32'h11, 1'b1, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_valid",   {31'h0, ms_to_ws_valid}, 32'h0);
            chk("reset_rf_we",   {31'h0, ms_rf_we},       32'h0);
            chk("reset_allowin", {31'h0, ms_allowin},     32'h1);
            chk("reset_pc",      ms_pc,                   32'h0);
            chk("reset_rfm",     {31'h0, ms_res_from_mem}, 32'h0);
        end
        es_to_ms_valid = 1'b0;
        resetn         = 1'b1;
        tick();

        // ---------------- table-driven single instructions ----------------
        for (int i = 0; i < 15; i++) begin
            present(vecs[i].pc, vecs[i].we, vecs[i].waddr, vecs[i].alu, vecs[i].rfm, vecs[i].ldop);
            ws_allowin = 1'b1;
            tick();
            es_to_ms_valid  = 1'b0;
            data_sram_rdata = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_wdata", i),   ms_rf_wdata,              vecs[i].exp_wdata);
            chk($sformatf("vec%0d_we", i),      {31'h0, ms_rf_we},        {31'h0, vecs[i].we});
            chk($sformatf("vec%0d_waddr", i),   {27'h0, ms_rf_waddr},     {27'h0, vecs[i].waddr});
            chk($sformatf("vec%0d_pc", i),      ms_pc,                    vecs[i].pc);
            chk($sformatf("vec%0d_valid", i),   {31'h0, ms_to_ws_valid},  32'h1);
            chk($sformatf("vec%0d_rfm", i),     {31'h0, ms_res_from_mem}, {31'h0, vecs[i].rfm});
            chk($sformatf("vec%0d_allowin", i), {31'h0, ms_allowin},      32'h1);
            tick();
        end

        // ---------------- stall capture -----------------------------------
        present(32'h1C000100, 1'b1, 5'd20, 32'h00002000, 1'b1, 3'd0);
        ws_allowin = 1'b1;
        tick();
        // Pending ALU instruction waits in execute during the stall.
        present(32'h1C000104, 1'b1, 5'd21, 32'h5A5A5A5A, 1'b0, 3'd0);
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'hAABBCCDD;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("stall%0d_wdata", i),   ms_rf_wdata,             32'hAABBCCDD);
            chk($sformatf("stall%0d_valid", i),   {31'h0, ms_to_ws_valid}, 32'h1);
            chk($sformatf("stall%0d_allowin", i), {31'h0, ms_allowin},     32'h0);
            chk($sformatf("stall%0d_pc", i),      ms_pc,                   32'h1C000100);
            tick();
            data_sram_rdata = 32'h11111111;
        end
        ws_allowin = 1'b1;
        #1;
        chk("stall_release_wdata",   ms_rf_wdata,         32'hAABBCCDD);
        chk("stall_release_allowin", {31'h0, ms_allowin}, 32'h1);
        // Drain and accept on the same edge: no bubble.
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk("drain_accept_valid", {31'h0, ms_to_ws_valid}, 32'h1);
        chk("drain_accept_pc",    ms_pc,                   32'h1C000104);
        chk("drain_accept_wdata", ms_rf_wdata,             32'h5A5A5A5A);
        tick();

        // ---------------- back-to-back loads ------------------------------
        present(32'h1C000200, 1'b1, 5'd1, 32'h00003000, 1'b1, 3'd0);
        ws_allowin = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            data_sram_rdata = i;
            if (i < 3)
                present(32'h1C000200 + 4 * i, 1'b1, 5'(i + 1), 32'h00003000 + 4 * i, 1'b1, 3'd0);
            else
                es_to_ms_valid = 1'b0;
            #1;
            chk($sformatf("b2b%0d_wdata", i),   ms_rf_wdata,         i);
            chk($sformatf("b2b%0d_allowin", i), {31'h0, ms_allowin}, 32'h1);
            chk($sformatf("b2b%0d_pc", i),      ms_pc,               32'h1C000200 + 4 * (i - 1));
            tick();
        end

        // ---------------- bubble ------------------------------------------
        data_sram_rdata = 32'h99999999;
        #1;
        chk("bubble_valid", {31'h0, ms_to_ws_valid},  32'h0);
        chk("bubble_rf_we", {31'h0, ms_rf_we},        32'h0);
        chk("bubble_rfm",   {31'h0, ms_res_from_mem}, 32'h0);
        chk("bubble_pc_kept", ms_pc,                  32'h1C000208);

        // ---------------- reset during a stalled load ---------------------
        present(32'h1C000300, 1'b1, 5'd9, 32'h00004000, 1'b1, 3'd0);
        tick();
        es_to_ms_valid  = 1'b0;
        ws_allowin      = 1'b0;
        data_sram_rdata = 32'hDEADBEEF;
        tick();
        data_sram_rdata = 32'h22222222;
        #1;
        chk("midrst_buffered", dut.rdata_buf_q, 32'hDEADBEEF);
        chk("midrst_wdata",    ms_rf_wdata,     32'hDEADBEEF);
        resetn = 1'b0;
        tick();
        chk("midrst_valid",   {31'h0, ms_to_ws_valid}, 32'h0);
        chk("midrst_buf",     dut.rdata_buf_q,         32'h0);
        chk("midrst_allowin", {31'h0, ms_allowin},     32'h1);
        resetn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
